// File: rtl/ex_sequencer_pkg.sv
// Shared definitions for the execute-stage sequencer: instruction classes,
// FSM state encoding and default field widths.
package ex_sequencer_pkg;

    localparam int DEF_OP_W   = 5;
    localparam int DEF_FLAG_W = 5;
    localparam int DEF_COND_W = 3;

    typedef enum logic [2:0] {
        CLS_NOP      = 3'd0,
        CLS_ALU_REG  = 3'd1,
        CLS_ALU_IMM  = 3'd2,
        CLS_LOAD     = 3'd3,
        CLS_STORE    = 3'd4,
        CLS_JUMP_REG = 3'd5,
        CLS_BRANCH   = 3'd6,
        CLS_HALT     = 3'd7
    } inst_class_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_PCUPD = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    // ALU op that passes operand A straight through (address pass-through).
    localparam logic [DEF_OP_W-1:0] ALU_OP_PASS = '0;

    function automatic logic is_alu_class(input inst_class_e cls);
        return (cls == CLS_ALU_REG) || (cls == CLS_ALU_IMM);
    endfunction

endpackage

// File: rtl/ex_ctrl_decode.sv
// Combinational map from sequencer state and latched instruction fields to
// every EX control input and core strobe.
module ex_ctrl_decode
    import ex_sequencer_pkg::*;
#(
    parameter int OP_W   = DEF_OP_W,
    parameter int FLAG_W = DEF_FLAG_W,
    parameter int COND_W = DEF_COND_W
) (
    input  state_e              state,
    input  inst_class_e         cls,
    input  logic [OP_W-1:0]     alu_op,
    input  logic [FLAG_W-1:0]   flag_mask,
    input  logic [COND_W-1:0]   cond,
    input  logic                tf,
    input  logic                taken,
    output logic [OP_W-1:0]     ula_op,
    output logic                mux_ext,
    output logic                mux_pc,
    output logic [FLAG_W-1:0]   flag_update,
    output logic [COND_W-1:0]   cond_jump,
    output logic                jump_tf,
    output logic                mem_we,
    output logic                reg_write,
    output logic                wb_sel,
    output logic                pc_write,
    output logic                pc_inc,
    output logic                halted
);

    logic busy;

    always_comb begin
        ula_op      = OP_W'(ALU_OP_PASS);
        mux_ext     = 1'b0;
        mux_pc      = 1'b0;
        flag_update = '0;
        cond_jump   = '0;
        jump_tf     = 1'b0;
        mem_we      = 1'b0;
        reg_write   = 1'b0;
        wb_sel      = 1'b0;
        pc_write    = 1'b0;
        pc_inc      = 1'b0;
        halted      = (state == ST_HALT);
        busy        = (state == ST_EXEC) || (state == ST_MEM) ||
                      (state == ST_WB)   || (state == ST_PCUPD);

        // Datapath selects stay stable for the whole instruction so the ALU
        // result is still valid when it is consumed in MEM/WB/PCUPD.
        if (busy && (cls != CLS_NOP) && (cls != CLS_HALT)) begin
            ula_op  = alu_op;
            mux_ext = (cls == CLS_ALU_IMM) || (cls == CLS_BRANCH);
            mux_pc  = (cls == CLS_BRANCH);
        end

        case (state)
            ST_EXEC: begin
                if (is_alu_class(cls)) begin
                    flag_update = flag_mask;
                end
                if (cls == CLS_BRANCH) begin
                    cond_jump = cond;
                    jump_tf   = tf;
                end
            end
            ST_MEM: begin
                if (cls == CLS_STORE) begin
                    mem_we = 1'b1;
                    pc_inc = 1'b1;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                wb_sel    = (cls == CLS_LOAD);
                pc_inc    = 1'b1;
            end
            ST_PCUPD: begin
                if (cls == CLS_BRANCH) begin
                    pc_write = taken;
                    pc_inc   = !taken;
                end else if (cls == CLS_JUMP_REG) begin
                    pc_write = 1'b1;
                end else begin
                    pc_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_sequencer.sv
// Multi-cycle execute-stage sequencer: accepts one decoded instruction per
// handshake, latches it, and walks it through EXEC/MEM/WB/PCUPD.
module ex_sequencer
    import ex_sequencer_pkg::*;
#(
    parameter int OP_W   = DEF_OP_W,
    parameter int FLAG_W = DEF_FLAG_W,
    parameter int COND_W = DEF_COND_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [2:0]        inst_class,
    input  logic [OP_W-1:0]   inst_alu_op,
    input  logic [FLAG_W-1:0] inst_flag_mask,
    input  logic [COND_W-1:0] inst_cond,
    input  logic              inst_tf,
    input  logic              hab_jump,
    output logic [OP_W-1:0]   ULA_OP,
    output logic              controleMuxExtensor,
    output logic              controleMuxPC,
    output logic [FLAG_W-1:0] atualizaFlag,
    output logic [COND_W-1:0] condicaoJump,
    output logic              Jump_True_False,
    output logic              Hab_EscritaMemoria,
    output logic              reg_write,
    output logic              wb_sel,
    output logic              pc_write,
    output logic              pc_inc,
    output logic              halted
);

    state_e              state_q, state_d;
    inst_class_e         cls_q, cls_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [FLAG_W-1:0]   mask_q, mask_d;
    logic [COND_W-1:0]   cond_q, cond_d;
    logic                tf_q, tf_d;
    logic                taken_q, taken_d;
    logic                accept;
    inst_class_e         in_cls;

    // Gated by reset_n so every output reads 0 while reset is held.
    assign inst_ready = (state_q == ST_IDLE) && reset_n;
    assign accept     = inst_valid && inst_ready;
    assign in_cls     = inst_class_e'(inst_class);

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        op_d    = op_q;
        mask_d  = mask_q;
        cond_d  = cond_q;
        tf_d    = tf_q;
        taken_d = taken_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cls_d   = in_cls;
                    op_d    = inst_alu_op;
                    mask_d  = inst_flag_mask;
                    cond_d  = inst_cond;
                    tf_d    = inst_tf;
                    taken_d = 1'b0;
                    case (in_cls)
                        CLS_NOP:  state_d = ST_PCUPD;
                        CLS_HALT: state_d = ST_HALT;
                        default:  state_d = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                // Flag tester result is only meaningful at the end of a branch's EXEC.
                if (cls_q == CLS_BRANCH) begin
                    taken_d = hab_jump;
                end
                case (cls_q)
                    CLS_ALU_REG, CLS_ALU_IMM:  state_d = ST_WB;
                    CLS_LOAD, CLS_STORE:       state_d = ST_MEM;
                    CLS_JUMP_REG, CLS_BRANCH:  state_d = ST_PCUPD;
                    default:                   state_d = ST_IDLE;
                endcase
            end
            ST_MEM:   state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_IDLE;
            ST_WB:    state_d = ST_IDLE;
            ST_PCUPD: state_d = ST_IDLE;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_NOP;
            op_q    <= '0;
            mask_q  <= '0;
            cond_q  <= '0;
            tf_q    <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            cond_q  <= cond_d;
            tf_q    <= tf_d;
            taken_q <= taken_d;
        end
    end

    ex_ctrl_decode #(
        .OP_W   (OP_W),
        .FLAG_W (FLAG_W),
        .COND_W (COND_W)
    ) u_decode (
        .state       (state_q),
        .cls         (cls_q),
        .alu_op      (op_q),
        .flag_mask   (mask_q),
        .cond        (cond_q),
        .tf          (tf_q),
        .taken       (taken_q),
        .ula_op      (ULA_OP),
        .mux_ext     (controleMuxExtensor),
        .mux_pc      (controleMuxPC),
        .flag_update (atualizaFlag),
        .cond_jump   (condicaoJump),
        .jump_tf     (Jump_True_False),
        .mem_we      (Hab_EscritaMemoria),
        .reg_write   (reg_write),
        .wb_sel      (wb_sel),
        .pc_write    (pc_write),
        .pc_inc      (pc_inc),
        .halted      (halted)
    );

endmodule
